// File: rtl/uart_rx_fifo.sv
// Byte FIFO behind uart_rx: edge-detected capture, FWFT valid/ready output, sticky overflow.
// Optional CR->CRLF expansion on the output side when CRLF_EXPAND_EN is defined.
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  byteReady,
  input  logic [7:0]            dataIn,
  output logic [7:0]            outData,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [7:0]          mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;
  logic                byte_ready_q;
  logic                push;
  logic                fifo_pop;
  logic                write_en;
  logic [7:0]          head;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                 (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign count = wr_ptr - rd_ptr;
  assign head  = mem[rd_ptr[DEPTH_LOG2-1:0]];

  // byteReady is a level from uart_rx; only its rising edge announces a new byte
  assign push     = byteReady && !byte_ready_q;
  assign write_en = push && (!full || fifo_pop);

`ifdef CRLF_EXPAND_EN
  typedef enum logic {PASS, LF} state_t;
  state_t state;

  always_comb begin
    outValid = 1'b0;
    outData  = 8'h00;
    fifo_pop = 1'b0;
    if (state == LF) begin
      outValid = 1'b1;
      outData  = 8'h0A;
    end else if (!empty) begin
      outValid = 1'b1;
      outData  = head;
      fifo_pop = outReady;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= PASS;
    end else begin
      case (state)
        PASS: if (fifo_pop && head == 8'h0D) state <= LF;
        LF:   if (outReady) state <= PASS;
        default: state <= PASS;
      endcase
    end
  end
`else
  assign outValid = !empty;
  assign outData  = empty ? 8'h00 : head;
  assign fifo_pop = outValid && outReady;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      overflow     <= 1'b0;
      byte_ready_q <= 1'b1;
    end else begin
      byte_ready_q <= byteReady;
      if (write_en) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && full && !fifo_pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (write_en && !reset) mem[wr_ptr[DEPTH_LOG2-1:0]] <= dataIn;
  end

endmodule
